// File: rtl/ct_spsram_arb_pkg.sv
// Shared types and constants for the two-port single-port-SRAM arbiter/controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ct_spsram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 128;

  localparam logic [1:0] WAIT = 2'b00;
  localparam logic [1:0] INIT = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;

  typedef enum logic [1:0] {
    S_WAIT = WAIT,
    S_INIT = INIT,
    S_RUN  = RUN
  } state_t;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// Two-way round-robin grant with a pointer that flips only on contested grants.
// Latency: grant is combinational; pointer updates on the clock after a contest.
// Backpressure: losing port simply sees no grant and holds its request.
module ct_spsram_rr_arb2
  import ct_spsram_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     vld0,
  input  logic     vld1,
  output logic     gnt0,
  output logic     gnt1,
  output port_id_t gnt_id
);

  port_id_t rr;

  // Pick the sole requester, or the rr-pointed port when both want the SRAM.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    gnt_id = PORT0;
    if (en) begin
      if (vld0 && vld1) begin
        gnt_id = rr;
        if (rr == PORT0) gnt0 = 1'b1;
        else             gnt1 = 1'b1;
      end else if (vld0) begin
        gnt0 = 1'b1;
      end else if (vld1) begin
        gnt1   = 1'b1;
        gnt_id = PORT1;
      end
    end
  end

  // Hand priority to the other port after each contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   rr <= PORT0;
    else if (en && vld0 && vld1)  rr <= ~rr;
  end

endmodule

// File: rtl/ct_spsram_arb_ctrl.sv
// Shares one single-port SRAM between two requesters, with zero-init sweep.
// Latency: request grant and SRAM drive are same-cycle; read data one cycle later.
// Backpressure: req_rdy is the grant; responses cannot be stalled.
module ct_spsram_arb_ctrl
  import ct_spsram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  p0_req_vld,
  input  logic                  p0_req_wr,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  input  logic [DATA_WIDTH-1:0] p0_req_wmask,
  output logic                  p0_req_rdy,
  output logic                  p0_rsp_vld,
  output logic [DATA_WIDTH-1:0] p0_rsp_data,
  input  logic                  p1_req_vld,
  input  logic                  p1_req_wr,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  input  logic [DATA_WIDTH-1:0] p1_req_wmask,
  output logic                  p1_req_rdy,
  output logic                  p1_rsp_vld,
  output logic [DATA_WIDTH-1:0] p1_rsp_data,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  run;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt_any;
  port_id_t              gnt_id;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] sel_wmask;
  logic                  rsp_vld_q;
  port_id_t              rsp_id_q;

  assign run       = (state == S_RUN);
  assign init_done = run;

  ct_spsram_rr_arb2 u_arb (
    .clk    (forever_cpuclk),
    .rst_n  (cpurst_b),
    .en     (run),
    .vld0   (p0_req_vld),
    .vld1   (p1_req_vld),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .gnt_id (gnt_id)
  );

  assign gnt_any    = gnt0 | gnt1;
  assign p0_req_rdy = gnt0;
  assign p1_req_rdy = gnt1;

  assign sel_wr    = gnt1 ? p1_req_wr    : p0_req_wr;
  assign sel_addr  = gnt1 ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = gnt1 ? p1_req_wdata : p0_req_wdata;
  assign sel_wmask = gnt1 ? p1_req_wmask : p0_req_wmask;

  // State register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state <= S_WAIT;
    else           state <= state_nxt;
  end

  // WAIT lasts one cycle; INIT ends after the top address; init_req restarts the sweep.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  state_nxt = INIT_EN ? S_INIT : S_RUN;
      S_INIT:  if (&init_cnt) state_nxt = S_RUN;
      S_RUN:   if (init_req)  state_nxt = S_INIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  // Sweep address; wraps back to 0 on the last INIT access so a re-init starts clean.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)             init_cnt <= '0;
    else if (state == S_INIT)  init_cnt <= init_cnt + 1'b1;
  end

  // SRAM pins: zero-fill during INIT, granted request during RUN, idle otherwise.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_addr = '0;
    sram_din  = '0;
    if (state == S_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_addr = init_cnt;
    end else if (gnt_any) begin
      sram_cen  = 1'b0;
      sram_addr = sel_addr;
      if (sel_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~sel_wmask;
        sram_din  = sel_wdata;
      end
    end
  end

  // Track which port owns the read data arriving next cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= PORT0;
    end else begin
      rsp_vld_q <= gnt_any && !sel_wr;
      rsp_id_q  <= gnt_id;
    end
  end

  assign p0_rsp_vld  = rsp_vld_q && (rsp_id_q == PORT0);
  assign p1_rsp_vld  = rsp_vld_q && (rsp_id_q == PORT1);
  assign p0_rsp_data = p0_rsp_vld ? sram_q : '0;
  assign p1_rsp_data = p1_rsp_vld ? sram_q : '0;

endmodule

// File: tb/tb_ct_spsram_arb_ctrl.sv
// Bench for ct_spsram_arb_ctrl with a behavioural SRAM and a reference memory model.
// Latency: checks read data one cycle after grant.
// Backpressure: models rr arbitration from contest history.
module tb_ct_spsram_arb_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 128;
  localparam int DEPTH = 1 << AW;
  localparam int RVW   = 7 + DW + AW + DW;

  typedef logic [DW-1:0] data_t;

  logic          clk;
  logic          cpurst_b;
  logic          init_req;
  logic          init_done;
  logic          p0_req_vld, p0_req_wr, p0_req_rdy, p0_rsp_vld;
  logic [AW-1:0] p0_req_addr;
  data_t         p0_req_wdata, p0_req_wmask, p0_rsp_data;
  logic          p1_req_vld, p1_req_wr, p1_req_rdy, p1_rsp_vld;
  logic [AW-1:0] p1_req_addr;
  data_t         p1_req_wdata, p1_req_wmask, p1_rsp_data;
  logic          sram_cen, sram_gwen;
  data_t         sram_wen, sram_din, sram_q;
  logic [AW-1:0] sram_addr;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected array contents and last contested winner.
  data_t ref_mem [DEPTH];
  int    last_win;
  data_t mem [DEPTH];

  ct_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_req(init_req), .init_done(init_done),
    .p0_req_vld(p0_req_vld), .p0_req_wr(p0_req_wr), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask), .p0_req_rdy(p0_req_rdy),
    .p0_rsp_vld(p0_rsp_vld), .p0_rsp_data(p0_rsp_data),
    .p1_req_vld(p1_req_vld), .p1_req_wr(p1_req_wr), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask), .p1_req_rdy(p1_req_rdy),
    .p1_rsp_vld(p1_rsp_vld), .p1_rsp_data(p1_rsp_data),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_q(sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: active-low strobes, registered Q on reads.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_addr] <= (mem[sram_addr] & sram_wen) | (sram_din & ~sram_wen);
      else            sram_q <= mem[sram_addr];
    end
  end

  function automatic logic [RVW-1:0] reset_view();
    return {init_done, p0_req_rdy, p1_req_rdy, p0_rsp_vld, p1_rsp_vld, sram_cen, sram_gwen,
            sram_wen, sram_addr, sram_din};
  endfunction

  function automatic logic [RVW-1:0] reset_want();
    return {7'b0000011, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}};
  endfunction

  // Expected winner from the arbitration rules: -1 none, else port index.
  function automatic int exp_grant(logic v0, logic v1);
    if (v0 && v1) return (last_win == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic data_t rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle();
    p0_req_vld = 0; p0_req_wr = 0; p0_req_addr = '0; p0_req_wdata = '0; p0_req_wmask = '0;
    p1_req_vld = 0; p1_req_wr = 0; p1_req_addr = '0; p1_req_wdata = '0; p1_req_wmask = '0;
    init_req = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_win = 1;
  endtask

  task automatic test_reset();
    idle();
    cpurst_b = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (reset_view() !== reset_want()) begin
      failures++; $display("FAIL reset_values: got %h want %h", reset_view(), reset_want());
    end
    p0_req_vld = 1; p1_req_vld = 1;
    cpurst_b = 1;
    #1;
    checks++;
    if ({sram_cen, p0_req_rdy, p1_req_rdy, init_done} !== 4'b1000) begin
      failures++; $display("FAIL wait_cycle: got %b want 1000", {sram_cen, p0_req_rdy, p1_req_rdy, init_done});
    end
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({sram_cen, sram_gwen, sram_wen, sram_din, sram_addr, p0_req_rdy, p1_req_rdy, init_done}
          !== {2'b00, {DW{1'b0}}, {DW{1'b0}}, AW'(k), 3'b000}) begin
        failures++;
        $display("FAIL init_sweep[%0d]: cen=%b gwen=%b wen=%h din=%h addr=%0d rdy=%b%b done=%b",
                 k, sram_cen, sram_gwen, sram_wen, sram_din, sram_addr, p0_req_rdy, p1_req_rdy, init_done);
      end
    end
    idle();
    @(negedge clk); #1;
    checks++;
    if (init_done !== 1'b1) begin
      failures++; $display("FAIL init_done_cycle18: got %b want 1", init_done);
    end
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_write_read();
    data_t pat = {16{8'hA5}};
    p0_req_vld = 1; p0_req_wr = 1; p0_req_addr = 3; p0_req_wdata = pat; p0_req_wmask = '1;
    #1;
    checks++;
    if ({p0_req_rdy, p1_req_rdy, sram_cen, sram_gwen, sram_addr, sram_din, sram_wen}
        !== {4'b1000, AW'(3), pat, {DW{1'b0}}}) begin
      failures++; $display("FAIL wr_drive: rdy=%b%b cen=%b gwen=%b addr=%0d din=%h wen=%h",
                           p0_req_rdy, p1_req_rdy, sram_cen, sram_gwen, sram_addr, sram_din, sram_wen);
    end
    ref_mem[3] = pat;
    @(negedge clk);
    p0_req_wr = 0;
    #1;
    checks++;
    if ({p0_req_rdy, p1_req_rdy, sram_cen, sram_gwen, sram_wen} !== {4'b1001, {DW{1'b1}}}) begin
      failures++; $display("FAIL rd_drive: rdy=%b%b cen=%b gwen=%b wen=%h",
                           p0_req_rdy, p1_req_rdy, sram_cen, sram_gwen, sram_wen);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({p0_rsp_vld, p1_rsp_vld, p0_rsp_data, p1_rsp_data} !== {2'b10, pat, {DW{1'b0}}}) begin
      failures++; $display("FAIL rd_rsp: vld=%b%b d0=%h d1=%h want 10 %h 0",
                           p0_rsp_vld, p1_rsp_vld, p0_rsp_data, p1_rsp_data, pat);
    end
    @(negedge clk); #1;
    checks++;
    if ({p0_rsp_vld, p1_rsp_vld} !== 2'b00) begin
      failures++; $display("FAIL rsp_single_cycle: got %b%b want 00", p0_rsp_vld, p1_rsp_vld);
    end
    @(negedge clk);
  endtask

  task automatic test_masks();
    data_t m = 128'h0F;
    // partial mask into zeroed addr 5
    p0_req_vld = 1; p0_req_wr = 1; p0_req_addr = 5; p0_req_wdata = '1; p0_req_wmask = m;
    #1;
    checks++;
    if (sram_wen !== ~m) begin
      failures++; $display("FAIL partial_wen: got %h want %h", sram_wen, ~m);
    end
    ref_mem[5] = (ref_mem[5] & ~m) | m;
    @(negedge clk);
    p0_req_wr = 0;
    @(negedge clk);
    idle(); #1;
    checks++;
    if (!p0_rsp_vld || p0_rsp_data !== ref_mem[5]) begin
      failures++; $display("FAIL partial_rd: vld=%b got %h want %h", p0_rsp_vld, p0_rsp_data, ref_mem[5]);
    end
    // zero mask write over addr 3 through port1 must change nothing
    @(negedge clk);
    p1_req_vld = 1; p1_req_wr = 1; p1_req_addr = 3; p1_req_wdata = '1; p1_req_wmask = '0;
    #1;
    checks++;
    if ({p1_req_rdy, sram_cen, sram_gwen, sram_wen} !== {3'b100, {DW{1'b1}}}) begin
      failures++; $display("FAIL zero_mask_drive: rdy=%b cen=%b gwen=%b wen=%h",
                           p1_req_rdy, sram_cen, sram_gwen, sram_wen);
    end
    @(negedge clk);
    p1_req_wr = 0;
    @(negedge clk);
    idle(); #1;
    checks++;
    if ({p0_rsp_vld, p1_rsp_vld} !== 2'b01 || p1_rsp_data !== ref_mem[3] || p0_rsp_data !== '0) begin
      failures++; $display("FAIL zero_mask_rd: vld=%b%b got %h want %h", p0_rsp_vld, p1_rsp_vld,
                           p1_rsp_data, ref_mem[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    data_t d1 = rnd_data();
    data_t d2 = rnd_data();
    p0_req_vld = 1; p0_req_wr = 1; p0_req_addr = 1; p0_req_wdata = d1; p0_req_wmask = '1;
    @(negedge clk);
    idle();
    p1_req_vld = 1; p1_req_wr = 1; p1_req_addr = 2; p1_req_wdata = d2; p1_req_wmask = '1;
    @(negedge clk);
    ref_mem[1] = d1; ref_mem[2] = d2;
    idle();
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        p0_req_vld = 1; p0_req_addr = 1; p1_req_vld = 1; p1_req_addr = 2;
      end else begin
        idle();
      end
      #1;
      if (k > 0) begin
        checks++;
        if (((k - 1) % 2) == 0) begin
          if ({p0_rsp_vld, p1_rsp_vld} !== 2'b10 || p0_rsp_data !== d1) begin
            failures++; $display("FAIL contend_rsp[%0d]: vld=%b%b d0=%h want 10 %h", k - 1,
                                 p0_rsp_vld, p1_rsp_vld, p0_rsp_data, d1);
          end
        end else begin
          if ({p0_rsp_vld, p1_rsp_vld} !== 2'b01 || p1_rsp_data !== d2) begin
            failures++; $display("FAIL contend_rsp[%0d]: vld=%b%b d1=%h want 01 %h", k - 1,
                                 p0_rsp_vld, p1_rsp_vld, p1_rsp_data, d2);
          end
        end
      end
      if (k < 4) begin
        checks++;
        if ({p0_req_rdy, p1_req_rdy} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL contend_gnt[%0d]: got %b%b want %s", k, p0_req_rdy, p1_req_rdy,
                               (k % 2 == 0) ? "10" : "01");
        end
        last_win = k % 2;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_traffic();
    bit    pend_vld = 0;
    int    pend_port = 0;
    data_t pend_data = '0;
    int    g;
    logic  wr;
    logic [AW-1:0] a;
    data_t d, m;
    for (int i = 0; i < 300; i++) begin
      p0_req_vld = ($urandom_range(0, 9) < 6); p0_req_wr = $urandom_range(0, 1);
      p0_req_addr = AW'($urandom_range(0, DEPTH - 1)); p0_req_wdata = rnd_data();
      p1_req_vld = ($urandom_range(0, 9) < 6); p1_req_wr = $urandom_range(0, 1);
      p1_req_addr = AW'($urandom_range(0, DEPTH - 1)); p1_req_wdata = rnd_data();
      case ($urandom_range(0, 3))
        0: p0_req_wmask = '0;
        1: p0_req_wmask = rnd_data();
        default: p0_req_wmask = '1;
      endcase
      p1_req_wmask = ($urandom_range(0, 1) != 0) ? rnd_data() : '1;
      #1;
      checks++;
      if ({p0_rsp_vld, p1_rsp_vld} !== (!pend_vld ? 2'b00 : (pend_port == 0 ? 2'b10 : 2'b01))
          || (pend_vld && pend_port == 0 && p0_rsp_data !== pend_data)
          || (pend_vld && pend_port == 1 && p1_rsp_data !== pend_data)
          || (!(pend_vld && pend_port == 0) && p0_rsp_data !== '0)
          || (!(pend_vld && pend_port == 1) && p1_rsp_data !== '0)) begin
        failures++; $display("FAIL rnd_rsp[%0d]: vld=%b%b d0=%h d1=%h want vld=%0d port=%0d data=%h",
                             i, p0_rsp_vld, p1_rsp_vld, p0_rsp_data, p1_rsp_data, pend_vld, pend_port, pend_data);
      end
      g = exp_grant(p0_req_vld, p1_req_vld);
      wr = (g == 1) ? p1_req_wr : p0_req_wr;
      a  = (g == 1) ? p1_req_addr : p0_req_addr;
      d  = (g == 1) ? p1_req_wdata : p0_req_wdata;
      m  = (g == 1) ? p1_req_wmask : p0_req_wmask;
      checks++;
      if (g < 0) begin
        if ({p0_req_rdy, p1_req_rdy, sram_cen, sram_gwen, sram_addr, sram_din} !== {4'b0011, {AW{1'b0}}, {DW{1'b0}}}) begin
          failures++; $display("FAIL rnd_idle[%0d]: rdy=%b%b cen=%b gwen=%b addr=%0d", i,
                               p0_req_rdy, p1_req_rdy, sram_cen, sram_gwen, sram_addr);
        end
      end else if ({p0_req_rdy, p1_req_rdy} !== ((g == 0) ? 2'b10 : 2'b01) || sram_cen !== 1'b0
                   || sram_addr !== a || sram_gwen !== !wr
                   || (wr && (sram_wen !== ~m || sram_din !== d)) || (!wr && sram_wen !== '1)) begin
        failures++; $display("FAIL rnd_gnt[%0d]: rdy=%b%b cen=%b gwen=%b addr=%0d want port=%0d wr=%b addr=%0d",
                             i, p0_req_rdy, p1_req_rdy, sram_cen, sram_gwen, sram_addr, g, wr, a);
      end
      pend_vld = 0;
      if (g >= 0) begin
        if (p0_req_vld && p1_req_vld) last_win = g;
        if (wr) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        else begin pend_vld = 1; pend_port = g; pend_data = ref_mem[a]; end
      end
      @(negedge clk);
    end
    idle();
    #1;
    checks++;
    if ({p0_rsp_vld, p1_rsp_vld} !== (!pend_vld ? 2'b00 : (pend_port == 0 ? 2'b10 : 2'b01))) begin
      failures++; $display("FAIL rnd_tail_rsp: vld=%b%b want vld=%0d port=%0d", p0_rsp_vld, p1_rsp_vld, pend_vld, pend_port);
    end
    @(negedge clk);
  endtask

  task automatic test_init_req();
    data_t d7 = rnd_data() | 128'h1;
    int    cnt;
    p0_req_vld = 1; p0_req_wr = 1; p0_req_addr = 7; p0_req_wdata = d7; p0_req_wmask = '1;
    @(negedge clk);
    idle();
    p1_req_vld = 1; p1_req_addr = 7; init_req = 1;
    #1;
    checks++;
    if ({p1_req_rdy, sram_cen, sram_gwen, sram_addr} !== {3'b101, AW'(7)}) begin
      failures++; $display("FAIL initreq_grant: rdy=%b cen=%b gwen=%b addr=%0d", p1_req_rdy, sram_cen, sram_gwen, sram_addr);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({p1_rsp_vld, p0_rsp_vld, init_done, sram_cen, sram_gwen, sram_addr} !== {5'b10000, {AW{1'b0}}}
        || p1_rsp_data !== d7) begin
      failures++; $display("FAIL initreq_rsp: vld1=%b vld0=%b done=%b cen=%b addr=%0d d1=%h want %h",
                           p1_rsp_vld, p0_rsp_vld, init_done, sram_cen, sram_addr, p1_rsp_data, d7);
    end
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      @(negedge clk); #1; cnt++;
    end
    checks++;
    if (cnt != DEPTH) begin
      failures++; $display("FAIL reinit_len: got %0d want %0d", cnt, DEPTH);
    end
    model_reset();
    last_win = last_win;
    p0_req_vld = 1; p0_req_addr = 7;
    @(negedge clk);
    idle(); #1;
    checks++;
    if (!p0_rsp_vld || p0_rsp_data !== '0) begin
      failures++; $display("FAIL reinit_zero: vld=%b got %h want 0", p0_rsp_vld, p0_rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cnt;
    init_req = 1;
    @(negedge clk);
    init_req = 0;
    repeat (3) @(negedge clk);
    #2 cpurst_b = 0;
    #1;
    checks++;
    if (reset_view() !== reset_want()) begin
      failures++; $display("FAIL rst_mid_init: got %h want %h", reset_view(), reset_want());
    end
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      cpurst_b = 1;
      #1;
      checks++;
      if (sram_cen !== 1'b1) begin
        failures++; $display("FAIL rst_wait[%0d]: cen=%b want 1", pass, sram_cen);
      end
      @(negedge clk); #1;
      checks++;
      if ({sram_cen, sram_gwen, sram_addr} !== {2'b00, {AW{1'b0}}}) begin
        failures++; $display("FAIL rst_restart[%0d]: cen=%b gwen=%b addr=%0d want 0 0 0", pass, sram_cen, sram_gwen, sram_addr);
      end
      cnt = 0;
      while (init_done !== 1'b1 && cnt < 40) begin
        checks++;
        if ({p0_rsp_vld, p1_rsp_vld} !== 2'b00) begin
          failures++; $display("FAIL rst_no_rsp[%0d]: vld=%b%b want 00", pass, p0_rsp_vld, p1_rsp_vld);
        end
        @(negedge clk); #1; cnt++;
      end
      checks++;
      if (cnt != DEPTH) begin
        failures++; $display("FAIL rst_init_len[%0d]: got %0d want %0d", pass, cnt, DEPTH);
      end
      if (pass == 0) begin
        p0_req_vld = 1; p0_req_addr = 4;
        #1;
        checks++;
        if (p0_req_rdy !== 1'b1) begin
          failures++; $display("FAIL rst_pre_grant: rdy=%b want 1", p0_req_rdy);
        end
        @(posedge clk);
        #1 cpurst_b = 0;
        #1;
        checks++;
        if (reset_view() !== reset_want()) begin
          failures++; $display("FAIL rst_after_grant: got %h want %h", reset_view(), reset_want());
        end
        idle();
      end
    end
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    cpurst_b = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_masks();
    test_contention();
    test_random_traffic();
    test_init_req();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ct_spsram_arb_ctrl.md
Name: ct_spsram_arb_ctrl

Overview:
- Controller that shares one single-port SRAM macro (ct_f_spsram_* family: active-low CEN/GWEN/WEN, synchronous read, Q valid one cycle after access) between two requesters.
- Provides a valid/ready request handshake per port and round-robin arbitration.
- Returns read data with fixed one-cycle latency.
- Performs hardware zero-initialisation of the whole array after reset or on request.
- Sits between L2/buffer logic and the SRAM wrapper.

Parameters:
- ADDR_WIDTH, 16, SRAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 128, SRAM data width.
- INIT_EN, 1, 1 = sweep-write zeros after reset; 0 = go straight to RUN.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- init_req  in  1  single-cycle pulse: re-run zero-init sweep.
- init_done  out  1  high when the array is initialised and ports are serviceable.
- p0_req_vld  in  1  port0 request valid.
- p0_req_wr  in  1  1 = write, 0 = read.
- p0_req_addr  in  ADDR_WIDTH  port0 address.
- p0_req_wdata  in  DATA_WIDTH  port0 write data.
- p0_req_wmask  in  DATA_WIDTH  port0 bit-write enable, active-high.
- p0_req_rdy  out  1  port0 request accepted this cycle.
- p0_rsp_vld  out  1  port0 read data valid.
- p0_rsp_data  out  DATA_WIDTH  port0 read data.
- p1_*  same set as p0_*, for port1.
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_gwen  out  1  SRAM global write enable, active-low.
- sram_wen  out  DATA_WIDTH  SRAM bit write enable, active-low.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_din  out  DATA_WIDTH  SRAM write data.
- sram_q  in  DATA_WIDTH  SRAM read data.

Behaviour:
- One clock, forever_cpuclk; reset cpurst_b is asynchronous, active-low.
- Reset values:
  - state = WAIT, init counter = 0, rr pointer = port0, rsp pipe cleared.
  - init_done = 0, p*_rdy = 0, p*_rsp_vld = 0.
  - sram_cen = 1, sram_gwen = 1, sram_wen = all 1, sram_addr = 0, sram_din = 0.
- States:
  - WAIT: one cycle after reset release, no SRAM access. Goes to INIT if INIT_EN = 1, else to RUN.
  - INIT: each cycle drives cen = 0, gwen = 0, wen = all 0, din = 0, addr = counter, then counter++. After the access at addr = depth-1, goes to RUN; counter wraps to 0. Takes exactly 2**ADDR_WIDTH cycles. rdy = 0 on both ports.
  - RUN: init_done = 1. Arbitrates requests, at most one SRAM access per cycle. init_req goes to INIT next cycle and clears init_done. If a request is granted in the same cycle as init_req, it completes; any read response still appears.
- Arbitration (RUN):
  - Grant is combinational from p*_req_vld and the rr pointer; p*_req_rdy = grant.
  - Only one vld: that port wins.
  - Both vld: the port pointed to by rr wins; rr then points to the other port.
  - rr updates only on a contested grant.
- SRAM drive on grant:
  - cen = 0, addr = req_addr.
  - Write: gwen = 0, wen = ~req_wmask, din = req_wdata.
  - Read: gwen = 1, wen = all 1.
- No grant: cen = 1, gwen = 1, wen = all 1; addr and din driven 0.
- Write with all-zero mask: still issued (cen = 0, gwen = 0, wen = all 1), so no bits change.
- Read response:
  - A read granted in cycle N gives p<i>_rsp_vld = 1 in cycle N+1, with p<i>_rsp_data = sram_q in that cycle.
  - The response port id is registered.
  - Back-to-back reads give responses on consecutive cycles.
  - There is no backpressure on responses; writes produce no response.
  - The non-owning port's rsp_data is driven 0.
- Reset mid-operation (any state) aborts immediately and drops any pending response. The sequence restarts from WAIT; array contents are undefined until the new INIT completes.

Decomposition:
- Shared package ct_spsram_arb_pkg holds:
  - state encoding localparams WAIT = 2'b00, INIT = 2'b01, RUN = 2'b10;
  - the port-id typedef (1 bit);
  - default width constants.
- Sub-module ct_spsram_rr_arb2: 2-way round-robin grant logic plus the rr pointer flop (async reset to port0).

Test Plan:
- Reset release, INIT_EN = 1, ADDR_WIDTH = 4 -> one WAIT cycle, then 16 cycles of cen = 0/gwen = 0/din = 0 at addr 0..15, then init_done = 1 at cycle 18; rdy = 0 throughout INIT.
- Port0 writes 0xA5..A5 to addr 3 with full mask, then reads addr 3 -> p0_rsp_vld one cycle after the read grant, data = 0xA5..A5; p1_rsp_vld stays 0.
- Partial mask: write 0xFF..FF with wmask = 0x0F to a zeroed addr, then read -> data = 0x0F (upper bits 0); sram_wen during the write = ~0x0F.
- Both ports vld for 4 cycles (p0 reads addr 1, p1 reads addr 2) -> grants alternate p0, p1, p0, p1; responses alternate with correct data one cycle later.
- init_req in RUN with p1 read granted the same cycle -> p1 response delivered next cycle; init_done drops; full sweep re-zeroes the array (prior write reads back 0).
- Assert cpurst_b mid-INIT and again the cycle after a read grant -> all outputs go to reset values asynchronously; no rsp_vld is emitted; the sweep restarts from addr 0.
